// File: rtl/frame_blend_palette.sv
// Pixel back-end: palette lookup plus previous-frame blend for LCD persistence.
// Two ce_pix stages; the previous frame is kept as raw indices, not colours.
module frame_blend_palette #(
  parameter int PIX_BITS  = 2,
  parameter int BUF_AW    = 15,
  parameter int BUF_DEPTH = 25600,
  parameter logic [24*(2**PIX_BITS)-1:0] DEF_PAL =
    96'h87BA6B_6BA378_386B82_384052
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ce_pix,
  input  logic [PIX_BITS-1:0] pixel,
  input  logic                hsync_i,
  input  logic                vsync_i,
  input  logic                hblank_i,
  input  logic                vblank_i,
  input  logic [1:0]          mode,
  input  logic                use_user_pal,
  input  logic                pal_wr,
  input  logic [7:0]          pal_addr,
  input  logic [7:0]          pal_din,
  output logic [7:0]          r,
  output logic [7:0]          g,
  output logic [7:0]          b,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic                hblank_o,
  output logic                vblank_o,
  output logic                de_o
);
  localparam int NE = 2**PIX_BITS;
  localparam logic [BUF_AW:0] DEPTH_L = (BUF_AW+1)'(BUF_DEPTH);

  typedef logic [PIX_BITS-1:0] pix_t;

  logic [23:0]     def_c [NE];
  logic [23:0]     pal_q [NE];
  pix_t            mem_q [BUF_DEPTH];
  logic [BUF_AW:0] addr_q, addr_d;
  logic [BUF_AW-1:0] ridx;
  logic            active, sat, wr_en, use_old;
  logic            vsd_q, wrote_q, pv_q;
  pix_t            pix1_q, old1_q;
  logic            hs1_q, vs1_q, hb1_q, vb1_q;
  logic [7:0]      r_q, g_q, b_q;
  logic            hs2_q, vs2_q, hb2_q, vb2_q, de_q;
  logic [23:0]     cur_c, old_c, mix_c;
  logic            pal_ok;
  pix_t            pal_ent;

  for (genvar gi = 0; gi < NE; gi++) begin : g_def
    assign def_c[gi] = DEF_PAL[(NE-1-gi)*24 +: 24];
  end

  assign active  = ~hblank_i & ~vblank_i;
  assign sat     = (addr_q == DEPTH_L);
  assign wr_en   = ce_pix & active & ~sat;
  assign use_old = active & ~sat & pv_q;
  assign ridx    = sat ? '0 : addr_q[BUF_AW-1:0];

  always_comb begin
    addr_d = addr_q;
    if (vsync_i)
      addr_d = '0;
    else if (active & ~sat)
      addr_d = addr_q + 1'b1;
  end

  // Non-blocking write gives read-before-write against old1_q.
  always_ff @(posedge clk_sys) begin
    if (wr_en)
      mem_q[ridx] <= pixel;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      addr_q  <= '0;
      vsd_q   <= 1'b0;
      wrote_q <= 1'b0;
      pv_q    <= 1'b0;
    end else if (ce_pix) begin
      addr_q <= addr_d;
      vsd_q  <= vsync_i;
      if (wr_en)
        wrote_q <= 1'b1;
      if (vsync_i & ~vsd_q & wrote_q)
        pv_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pix1_q <= '0;
      old1_q <= '0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      hb1_q  <= 1'b0;
      vb1_q  <= 1'b0;
    end else if (ce_pix) begin
      pix1_q <= pixel;
      old1_q <= use_old ? mem_q[ridx] : pixel;
      hs1_q  <= hsync_i;
      vs1_q  <= vsync_i;
      hb1_q  <= hblank_i;
      vb1_q  <= vblank_i;
    end
  end

  function automatic logic [7:0] mix(
    input logic [1:0] m,
    input logic [7:0] a,
    input logic [7:0] o
  );
    logic [8:0] s1;
    logic [9:0] s3;
    logic [7:0] res;
    s1 = {1'b0, a} + {1'b0, o};
    s3 = {2'b0, a} + {1'b0, a, 1'b0} + {2'b0, o};
    unique case (m)
      2'd0:    res = a;
      2'd1:    res = s1[8:1];
      2'd2:    res = s3[9:2];
      default: res = (a > o) ? a : o;
    endcase
    return res;
  endfunction

  always_comb begin
    cur_c = use_user_pal ? pal_q[pix1_q] : def_c[pix1_q];
    old_c = use_user_pal ? pal_q[old1_q] : def_c[old1_q];
    mix_c = {mix(mode, cur_c[23:16], old_c[23:16]),
             mix(mode, cur_c[15:8],  old_c[15:8]),
             mix(mode, cur_c[7:0],   old_c[7:0])};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      hb2_q <= 1'b0;
      vb2_q <= 1'b0;
      de_q  <= 1'b0;
    end else if (ce_pix) begin
      if (hb1_q | vb1_q) begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end else begin
        r_q <= mix_c[23:16];
        g_q <= mix_c[15:8];
        b_q <= mix_c[7:0];
      end
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      hb2_q <= hb1_q;
      vb2_q <= vb1_q;
      de_q  <= ~(hb1_q | vb1_q);
    end
  end

  assign pal_ok  = pal_wr & ((pal_addr >> (PIX_BITS+2)) == 8'd0) &
                   (pal_addr[1:0] != 2'd3);
  assign pal_ent = pal_addr[PIX_BITS+1:2];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < NE; i++)
        pal_q[i] <= def_c[i];
    end else if (pal_ok) begin
      unique case (pal_addr[1:0])
        2'd0:    pal_q[pal_ent][23:16] <= pal_din;
        2'd1:    pal_q[pal_ent][15:8]  <= pal_din;
        default: pal_q[pal_ent][7:0]   <= pal_din;
      endcase
    end
  end

  assign r        = r_q;
  assign g        = g_q;
  assign b        = b_q;
  assign hsync_o  = hs2_q;
  assign vsync_o  = vs2_q;
  assign hblank_o = hb2_q;
  assign vblank_o = vb2_q;
  assign de_o     = de_q;

endmodule

// File: tb/tb_frame_blend_palette.sv
// Bench for frame_blend_palette: frame-level reference model
// with per-pixel expected outputs, small buffer for short runs.
module tb_frame_blend_palette;
  localparam int PB = 2;
  localparam int AW = 6;
  localparam int DEPTH = 64;

  logic clk_sys = 0, reset = 0, ce_pix = 0;
  logic [PB-1:0] pixel = '0;
  logic hsync_i = 0, vsync_i = 0, hblank_i = 0, vblank_i = 0;
  logic [1:0] mode = 0;
  logic use_user_pal = 0, pal_wr = 0;
  logic [7:0] pal_addr = 0, pal_din = 0;
  logic [7:0] r, g, b;
  logic hsync_o, vsync_o, hblank_o, vblank_o, de_o;

  frame_blend_palette #(
    .PIX_BITS(PB), .BUF_AW(AW), .BUF_DEPTH(DEPTH)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
    .pixel(pixel), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .hblank_i(hblank_i), .vblank_i(vblank_i), .mode(mode),
    .use_user_pal(use_user_pal), .pal_wr(pal_wr),
    .pal_addr(pal_addr), .pal_din(pal_din),
    .r(r), .g(g), .b(b), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .hblank_o(hblank_o), .vblank_o(vblank_o), .de_o(de_o)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {int pix; bit hs, vs, hb, vb;} stim_t;
  typedef struct {int cur, old; bit hs, vs, hb, vb;} pend_t;

  int checks = 0, errors = 0;
  stim_t st[$];
  logic [28:0] exp_o, got_o;
  int defp[4] = '{32'h87BA6B, 32'h6BA378, 32'h386B82, 32'h384052};
  int upal[4];
  int m_buf[DEPTH];
  int m_addr;
  bit m_pv, m_wrote, m_vsd;
  pend_t pend;

  function automatic int chan(int c, int k);
    return (c >> (16 - 8*k)) & 255;
  endfunction

  function automatic int blend1(int m, int a, int o);
    case (m)
      0: return a;
      1: return (a + o) / 2;
      2: return (3*a + o) / 4;
      default: return (a > o) ? a : o;
    endcase
  endfunction

  function automatic int colour(int idx, bit user);
    return user ? upal[idx] : defp[idx];
  endfunction

  task automatic drive(stim_t s, bit ce_v = 1'b1);
    int rgb, k, e;
    bit act, wr;
    @(negedge clk_sys);
    pixel = s.pix[PB-1:0];
    hsync_i = s.hs; vsync_i = s.vs;
    hblank_i = s.hb; vblank_i = s.vb;
    ce_pix = ce_v;
    if (ce_v) begin
      rgb = 0;
      if (!(pend.hb || pend.vb))
        for (int c = 0; c < 3; c++)
          rgb |= blend1(mode,
            chan(colour(pend.cur, use_user_pal), c),
            chan(colour(pend.old, use_user_pal), c)) << (16 - 8*c);
      exp_o = {rgb[23:0], pend.hs, pend.vs, pend.hb, pend.vb,
               !(pend.hb || pend.vb)};
      act = !s.hb && !s.vb;
      wr = act && (m_addr < DEPTH);
      pend = '{s.pix, (wr && m_pv) ? m_buf[m_addr] : s.pix,
               s.hs, s.vs, s.hb, s.vb};
      if (wr) m_buf[m_addr] = s.pix;
      if (s.vs && !m_vsd && m_wrote) m_pv = 1;
      m_vsd = s.vs;
      if (wr) m_wrote = 1;
      if (s.vs) m_addr = 0;
      else if (wr) m_addr++;
    end
    if (pal_wr && pal_addr < 16 && pal_addr % 4 != 3) begin
      k = pal_addr % 4;
      e = pal_addr / 4;
      upal[e] = (upal[e] & ~(255 << (16 - 8*k))) |
                (int'(pal_din) << (16 - 8*k));
    end
    @(posedge clk_sys);
    #1;
    got_o = {r, g, b, hsync_o, vsync_o, hblank_o, vblank_o, de_o};
    pal_wr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1; ce_pix = 1; pal_wr = 0;
    @(posedge clk_sys);
    #1;
    got_o = {r, g, b, hsync_o, vsync_o, hblank_o, vblank_o, de_o};
    m_addr = 0; m_pv = 0; m_wrote = 0; m_vsd = 0;
    foreach (upal[i]) upal[i] = defp[i];
    pend = '{0, 0, 0, 0, 0, 0};
    exp_o = '0;
    @(negedge clk_sys);
    reset = 0; ce_pix = 0;
  endtask

  // pat: 0 constant v, 1 alternating 0/3, 2 random
  task automatic gen_frame(int w, int h, int pat, int v);
    int p;
    st.delete();
    for (int i = 0; i < w + 4; i++)
      st.push_back('{$urandom_range(0, 3), 1'b0,
                     (i >= 1 && i < 3), 1'b1, 1'b1});
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w + 3; x++) begin
        p = (pat == 0) ? v : (pat == 1) ? (((x + y) % 2) ? 3 : 0)
                                        : $urandom_range(0, 3);
        st.push_back('{p, (x == w + 1), 1'b0, (x >= w), 1'b0});
      end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (got_o !== 29'b0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", got_o);
    end
    checks++;
    if ({r, g, b, de_o} !== 25'b0) begin
      errors++; $display("FAIL reset_hold got %h want 0", {r, g, b, de_o});
    end
    checks++;
    if (dut.addr_q !== 7'd0) begin
      errors++; $display("FAIL reset_addr got %0d want 0", dut.addr_q);
    end
    checks++;
    if (dut.pv_q !== 1'b0) begin
      errors++; $display("FAIL reset_pv got %b want 0", dut.pv_q);
    end
  endtask

  task automatic test_first_frame();
    mode = 1; use_user_pal = 0;
    gen_frame(8, 8, 1, 0);
    foreach (st[i]) begin
      drive(st[i]);
      checks++;
      if (got_o !== exp_o || dut.pv_q !== m_pv) begin
        errors++;
        $display("FAIL first_frame i=%0d got %h/%b want %h/%b",
                 i, got_o, dut.pv_q, exp_o, m_pv);
      end
      if (i > 0 && !st[i-1].hb && !st[i-1].vb) begin
        checks++;
        if (got_o[28:5] !== defp[st[i-1].pix][23:0]) begin
          errors++;
          $display("FAIL first_unblended i=%0d got %h want %h",
                   i, got_o[28:5], defp[st[i-1].pix][23:0]);
        end
      end
    end
    checks++;
    if (dut.pv_q !== 1'b0) begin
      errors++; $display("FAIL pv_after_first got %b want 0", dut.pv_q);
    end
    gen_frame(8, 8, 0, 3);
    foreach (st[i]) begin
      drive(st[i]);
      checks++;
      if (got_o !== exp_o || dut.pv_q !== m_pv) begin
        errors++;
        $display("FAIL second_frame i=%0d got %h/%b want %h/%b",
                 i, got_o, dut.pv_q, exp_o, m_pv);
      end
    end
    checks++;
    if (dut.pv_q !== 1'b1) begin
      errors++; $display("FAIL pv_after_second got %b want 1", dut.pv_q);
    end
  endtask

  task automatic test_blend_modes();
    int pixs[5]  = '{0, 3, 0, 3, 0};
    int modes[5] = '{1, 1, 2, 0, 3};
    int wants[5] = '{32'h5F7D5E, 32'h5F7D5E, 32'h739B64,
                     32'h384052, 32'h87BA6B};
    use_user_pal = 0;
    for (int j = 0; j < 5; j++) begin
      mode = modes[j][1:0];
      gen_frame(8, 8, 0, pixs[j]);
      foreach (st[i]) begin
        drive(st[i]);
        checks++;
        if (got_o !== exp_o) begin
          errors++;
          $display("FAIL blend_model j=%0d i=%0d got %h want %h",
                   j, i, got_o, exp_o);
        end
        if (i > 0 && !st[i-1].hb && !st[i-1].vb) begin
          checks++;
          if (got_o[28:5] !== wants[j][23:0]) begin
            errors++;
            $display("FAIL blend_const j=%0d i=%0d got %h want %h",
                     j, i, got_o[28:5], wants[j][23:0]);
          end
        end
      end
    end
  endtask

  task automatic test_user_pal();
    int dat[3] = '{8'hFF, 8'h00, 8'h80};
    int pixs[3] = '{1, 0, 1};
    int wants[3] = '{32'hFF0080, 32'h87BA6B, 32'hFF0080};
    use_user_pal = 1; mode = 0;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        pal_wr = 1; pal_addr = 8'(4 + k); pal_din = dat[k][7:0];
      end else begin
        pal_wr = 1; pal_addr = (k == 3) ? 8'h03 : 8'h40; pal_din = 8'h11;
      end
      drive('{0, 0, 0, 1, 1});
      checks++;
      if (got_o !== exp_o) begin
        errors++; $display("FAIL pal_write k=%0d got %h want %h",
                           k, got_o, exp_o);
      end
    end
    for (int j = 0; j < 3; j++) begin
      gen_frame(8, 8, 0, pixs[j]);
      foreach (st[i]) begin
        drive(st[i]);
        checks++;
        if (got_o !== exp_o) begin
          errors++; $display("FAIL user_pal j=%0d i=%0d got %h want %h",
                             j, i, got_o, exp_o);
        end
        if (i > 0 && !st[i-1].hb && !st[i-1].vb) begin
          checks++;
          if (got_o[28:5] !== wants[j][23:0]) begin
            errors++;
            $display("FAIL user_pal_const j=%0d got %h want %h",
                     j, got_o[28:5], wants[j][23:0]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      gen_frame(8, 8, 2, 0);
      foreach (st[i]) begin
        mode = 2'($urandom_range(0, 3));
        use_user_pal = 1'($urandom_range(0, 1));
        pal_wr = ($urandom_range(0, 3) == 0);
        pal_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 15));
        pal_din = 8'($urandom);
        drive(st[i]);
        checks++;
        if (got_o !== exp_o) begin
          errors++; $display("FAIL random f=%0d i=%0d got %h want %h",
                             f, i, got_o, exp_o);
        end
      end
    end
  endtask

  task automatic test_overflow();
    mode = 1; use_user_pal = 0;
    for (int f = 0; f < 2; f++) begin
      gen_frame(f == 0 ? 10 : 8, 8, 2, 0);
      foreach (st[i]) begin
        drive(st[i]);
        checks++;
        if (got_o !== exp_o) begin
          errors++; $display("FAIL overflow f=%0d i=%0d got %h want %h",
                             f, i, got_o, exp_o);
        end
      end
      if (f == 0) begin
        checks++;
        if (dut.addr_q !== 7'd64) begin
          errors++; $display("FAIL addr_sat got %0d want 64", dut.addr_q);
        end
      end
    end
    st.delete();
    for (int x = 0; x < 5; x++)
      st.push_back('{$urandom_range(0, 3), 1'b0, 1'b0, 1'b0, 1'b0});
    st.push_back('{2, 1'b0, 1'b1, 1'b0, 1'b0});
    foreach (st[i]) begin
      drive(st[i]);
      checks++;
      if (got_o !== exp_o) begin
        errors++; $display("FAIL vs_midline i=%0d got %h want %h",
                           i, got_o, exp_o);
      end
    end
    checks++;
    if (dut.addr_q !== 7'd0) begin
      errors++; $display("FAIL addr_vs_clear got %0d want 0", dut.addr_q);
    end
  endtask

  task automatic test_ce_hold();
    logic [28:0] held;
    mode = 2; use_user_pal = 0;
    gen_frame(8, 8, 2, 0);
    foreach (st[i]) begin
      if (i == 20) begin
        held = got_o;
        for (int k = 0; k < 5; k++) begin
          drive('{$urandom_range(0, 3), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom)}, 1'b0);
          checks++;
          if (got_o !== held) begin
            errors++; $display("FAIL ce_hold k=%0d got %h want %h",
                               k, got_o, held);
          end
        end
      end
      drive(st[i]);
      checks++;
      if (got_o !== exp_o) begin
        errors++; $display("FAIL ce_frame i=%0d got %h want %h",
                           i, got_o, exp_o);
      end
    end
  endtask

  task automatic test_reset_midframe();
    mode = 1; use_user_pal = 0;
    gen_frame(8, 8, 2, 0);
    for (int i = 0; i < 40; i++) begin
      drive(st[i]);
      checks++;
      if (got_o !== exp_o) begin
        errors++; $display("FAIL pre_reset i=%0d got %h want %h",
                           i, got_o, exp_o);
      end
    end
    do_reset();
    checks++;
    if (got_o !== 29'b0) begin
      errors++; $display("FAIL midframe_flush got %h want 0", got_o);
    end
    gen_frame(8, 8, 1, 0);
    foreach (st[i]) begin
      drive(st[i]);
      checks++;
      if (got_o !== exp_o) begin
        errors++; $display("FAIL post_reset i=%0d got %h want %h",
                           i, got_o, exp_o);
      end
      if (i > 0 && !st[i-1].hb && !st[i-1].vb) begin
        checks++;
        if (got_o[28:5] !== defp[st[i-1].pix][23:0]) begin
          errors++; $display("FAIL post_reset_unblended i=%0d got %h",
                             i, got_o[28:5]);
        end
      end
    end
  endtask

  initial begin
    foreach (m_buf[i]) m_buf[i] = 0;
    test_reset();
    test_first_frame();
    test_blend_modes();
    test_user_pal();
    test_random();
    test_overflow();
    test_ce_hold();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
